mem_access_ctrl: RTL

Load/store access controller that sits between the execute/memory stage of the ARMv8 pipeline and the byte-addressed, 64-bit-wide data memory. It accepts one LDUR/STUR-family request at a time: byte, halfword, word or doubleword, signed or unsigned. It drives the memory's address, write-data and read/write strobes, and returns the aligned, extended load result. Sub-doubleword stores use a read-modify-write (RMW) sequence because the memory only transfers whole 8-byte lines.

---
 rtl/mem_ctrl_pkg.sv | 40 ++++
 rtl/mem_lane_align.sv | 40 ++++
 rtl/mem_access_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the ARMv8 load/store access controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } accSize_e;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    RESP,
    FAULT
  } ctrlState_e;

  localparam int DEFAULT_MEM_SIZE = 100;

  function automatic logic [63:0] sizeMask(accSize_e size);
    case (size)
      SZ_B:    return 64'h0000_0000_0000_00FF;
      SZ_H:    return 64'h0000_0000_0000_FFFF;
      SZ_W:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // A natural-alignment violation for the access size at byte lane `lane`.
  function automatic logic isMisaligned(accSize_e size, logic [2:0] lane);
    case (size)
      SZ_H:    return lane[0];
      SZ_W:    return |lane[1:0];
      SZ_D:    return |lane;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a 64-bit memory line and a sized access:
// load extract/extend and store byte-merge.
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [63:0] line,
  input  logic [2:0]  lane,
  input  accSize_e    size,
  input  logic        isSigned,
  input  logic [63:0] wdata,
  output logic [63:0] loadData,
  output logic [63:0] storeLine
);

  logic [5:0]  shamt;
  logic [63:0] shifted;
  logic [63:0] mask;

  assign shamt   = {lane, 3'b000};
  assign shifted = line >> shamt;
  assign mask    = sizeMask(size);

  // NOTE: loadData gets its zero-extended default before the case, so every
  // path assigns it and no latch is inferred.
  always_comb begin
    loadData = shifted & mask;
    if (isSigned) begin
      case (size)
        SZ_B:    loadData = {{56{shifted[7]}}, shifted[7:0]};
        SZ_H:    loadData = {{48{shifted[15]}}, shifted[15:0]};
        SZ_W:    loadData = {{32{shifted[31]}}, shifted[31:0]};
        default: loadData = shifted;
      endcase
    end
  end

  // A dword store has an all-ones mask at lane 0, so this yields wdata as-is.
  assign storeLine = (line & ~(mask << shamt)) | ((wdata & mask) << shamt);

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store access controller between the ARMv8 memory stage and a 64-bit
// line memory. Define MEM_ACCESS_BOUNDS_CHECK_EN to fault out-of-range lines.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int MEM_SIZE = DEFAULT_MEM_SIZE,
  parameter int ADDR_W   = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [63:0]       i_wdata,
  output logic              o_ready,
  output logic              o_done,
  output logic              o_fault,
  output logic [63:0]       o_rdata,
  output logic [63:0]       o_memAdd,
  output logic [63:0]       o_memDataWr,
  output logic              o_memRd,
  output logic              o_memWr,
  input  logic [63:0]       i_memDataRd
);

  ctrlState_e        state, stateNext;
  logic [ADDR_W-1:0] addrQ;
  accSize_e          sizeQ;
  logic              weQ;
  logic              signedQ;
  logic [63:0]       wdataQ;
  logic [63:0]       lineQ;
  logic [63:0]       rdataQ;

  accSize_e          sizeIn;
  logic              outOfBounds;
  logic              accFault;
  logic [ADDR_W-1:0] addrBase;
  logic [63:0]       lineSel;
  logic [63:0]       loadData;
  logic [63:0]       storeLine;

  assign sizeIn = accSize_e'(i_size);

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  // One extra bit keeps base+7 from wrapping near the top of the address space.
  logic [ADDR_W:0] lastByte;
  assign lastByte    = {1'b0, i_addr & ~ADDR_W'(7)} + (ADDR_W+1)'(7);
  assign outOfBounds = lastByte >= (ADDR_W+1)'(MEM_SIZE);
`else
  assign outOfBounds = 1'b0;
`endif

  assign accFault = isMisaligned(sizeIn, i_addr[2:0]) | outOfBounds;
  assign addrBase = addrQ & ~ADDR_W'(7);

  // READ extracts straight from the memory response; WRITE merges the captured line.
  assign lineSel = (state == READ) ? i_memDataRd : lineQ;

  mem_lane_align u_laneAlign (
    .line      (lineSel),
    .lane      (addrQ[2:0]),
    .size      (sizeQ),
    .isSigned  (signedQ),
    .wdata     (wdataQ),
    .loadData  (loadData),
    .storeLine (storeLine)
  );

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (i_req) begin
          if (accFault)                      stateNext = FAULT;
          else if (!i_we || sizeIn != SZ_D)  stateNext = READ;
          else                               stateNext = WRITE;
        end
      end
      READ:        stateNext = weQ ? WRITE : RESP;
      WRITE:       stateNext = RESP;
      RESP, FAULT: stateNext = IDLE;
      default:     stateNext = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so each register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      addrQ   <= '0;
      sizeQ   <= SZ_B;
      weQ     <= 1'b0;
      signedQ <= 1'b0;
      wdataQ  <= '0;
      lineQ   <= '0;
      rdataQ  <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && i_req) begin
        addrQ   <= i_addr;
        sizeQ   <= sizeIn;
        weQ     <= i_we;
        signedQ <= i_signed;
        wdataQ  <= i_wdata;
      end
      if (state == READ) begin
        lineQ <= i_memDataRd;
        if (!weQ) rdataQ <= loadData;
      end
    end
  end

  assign o_ready     = (state == IDLE);
  assign o_done      = (state == RESP) || (state == FAULT);
  assign o_fault     = (state == FAULT);
  assign o_rdata     = rdataQ;
  assign o_memRd     = (state == READ);
  assign o_memWr     = (state == WRITE);
  assign o_memAdd    = (o_memRd || o_memWr) ? 64'(addrBase) : 64'd0;
  assign o_memDataWr = o_memWr ? storeLine : 64'd0;

endmodule
